seg_scan_ctrl: RTL and testbench

Time-multiplexing scan controller for the multiplier's 7-segment display bank. It latches a multi-digit hex value, such as the 16-bit product, and sequences the digits one at a time onto a shared digit code/segment-decoder path. It drives active-low digit enables and supports optional leading-zero blanking. It sits between the multiplier result register and the segment encoder. New values are committed only at frame boundaries, so a displayed frame never mixes old and new digits.

---
 rtl/seg_scan_ctrl.sv | 123 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl
// Description : Time-multiplexed 7-segment scan controller. Latches a
//               multi-digit hex value into a shadow register and commits it
//               to the display register only at frame boundaries. The digits
//               are then presented one at a time on a shared code path, with
//               active-low digit enables and optional leading-zero blanking.
// Ports       : clk          - rising-edge clock
//               rst_n        - asynchronous active-low reset
//               load         - single-cycle strobe, captures value
//               value        - 4*DIGITS hex value, nibble 0 least significant
//               blank_lz     - leading-zero blanking enable (live level)
//               an           - active-low digit enables, at most one low
//               digit_code   - nibble of the current digit
//               digit_blank  - current digit is blanked
//               pending      - a loaded value awaits frame commit
//               frame_start  - one-cycle pulse when digit 0 becomes active
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  blank_lz,
  output logic [DIGITS-1:0]     an,
  output logic [3:0]            digit_code,
  output logic                  digit_blank,
  output logic                  pending,
  output logic                  frame_start
);

  localparam int c_PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int c_IDX_W = $clog2(DIGITS);
  localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(DIV - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DIGITS - 1);

  logic [c_PRE_W-1:0]    r_pre;
  logic [c_IDX_W-1:0]    r_idx;
  logic [4*DIGITS-1:0]   r_display;
  logic [4*DIGITS-1:0]   r_shadow;
  logic                  r_pending;
  logic                  r_frame_start;

  logic                  w_tick;
  logic                  w_wrap;
  logic [DIGITS-1:0]     w_nz;          // per-digit "nibble is non-zero"
  logic [DIGITS-1:0]     w_upper_zero;  // nibbles i..DIGITS-1 all zero
  logic                  w_blank;

  assign w_tick = (r_pre == c_PRE_LAST);
  assign w_wrap = w_tick && (r_idx == c_IDX_LAST);

  // Prescaler and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
      r_idx <= w_wrap ? '0 : r_idx + c_IDX_W'(1);
    end else begin
      r_pre <= r_pre + c_PRE_W'(1);
    end
  end

  // Shadow / display handoff. On a coincident load and wrap the commit
  // takes the old shadow (non-blocking read), while the new value lands in
  // shadow and stays pending for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow      <= '0;
      r_display     <= '0;
      r_pending     <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      if (load) begin
        r_shadow <= value;
      end
      if (w_wrap && r_pending) begin
        r_display <= r_shadow;
      end
      if (load) begin
        r_pending <= 1'b1;
      end else if (w_wrap) begin
        r_pending <= 1'b0;
      end
      r_frame_start <= w_wrap;
    end
  end

  // Leading-zero detection: digit i is a leading zero when it and every
  // more significant digit are zero.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_zero
    assign w_nz[gi]         = |r_display[4*gi +: 4];
    assign w_upper_zero[gi] = ~|(w_nz >> gi);
  end

  // Output decode, purely from registered state plus the live blank_lz.
  always_comb begin
    digit_code = 4'h0;
    w_blank    = 1'b0;
    an         = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == c_IDX_W'(i)) begin
        digit_code = r_display[4*i +: 4];
        // Digit 0 is never blanked so a zero value still shows "0".
        w_blank    = blank_lz && (i != 0) && w_upper_zero[i];
        an[i]      = w_blank;
      end
    end
  end

  assign digit_blank = w_blank;
  assign pending     = r_pending;
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_ctrl
// Description : Self-checking bench for seg_scan_ctrl (DIGITS=4, DIV=4).
//               A reference model tracks edges since reset and derives the
//               scan position, commits and blanking arithmetically.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int FRAME  = DIGITS * DIV;

  logic                clk;
  logic                rst_n;
  logic                load;
  logic [4*DIGITS-1:0] value;
  logic                blank_lz;
  logic [DIGITS-1:0]   an;
  logic [3:0]          digit_code;
  logic                digit_blank;
  logic                pending;
  logic                frame_start;

  int n_chk;
  int n_err;

  // reference model state
  int                  m_cyc;   // rising edges since reset release
  logic [4*DIGITS-1:0] m_disp;
  logic [4*DIGITS-1:0] m_shad;
  logic                m_pend;
  logic                m_fs;

  seg_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .value       (value),
    .blank_lz    (blank_lz),
    .an          (an),
    .digit_code  (digit_code),
    .digit_blank (digit_blank),
    .pending     (pending),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cyc  = 0;
    m_disp = '0;
    m_shad = '0;
    m_pend = 1'b0;
    m_fs   = 1'b0;
  endtask

  // Compare every output against the model at the current scan position.
  task automatic check_all(input string tag);
    int                pos;
    logic [3:0]        e_code;
    logic              e_bl;
    logic [DIGITS-1:0] e_an;
    pos    = (m_cyc / DIV) % DIGITS;
    e_code = 4'((m_disp >> (4 * pos)) & 16'hF);
    e_bl   = blank_lz && (pos != 0) && ((m_disp >> (4 * pos)) == 0);
    e_an   = '1;
    if (!e_bl) e_an[pos] = 1'b0;
    chk({tag, ".an"},          32'(an),          32'(e_an));
    chk({tag, ".code"},        32'(digit_code),  32'(e_code));
    chk({tag, ".blank"},       32'(digit_blank), 32'(e_bl));
    chk({tag, ".pending"},     32'(pending),     32'(m_pend));
    chk({tag, ".frame_start"}, 32'(frame_start), 32'(m_fs));
  endtask

  // One clock: drive inputs, take the edge, advance the model, check.
  task automatic cycle(input logic ld, input logic [4*DIGITS-1:0] v, input string tag);
    logic wrap;
    load  = ld;
    value = v;
    @(posedge clk);
    wrap = ((m_cyc % FRAME) == FRAME - 1);
    if (wrap && m_pend) m_disp = m_shad;
    if (wrap) m_pend = 1'b0;
    if (ld) begin
      m_shad = v;
      m_pend = 1'b1;
    end
    m_fs = wrap;
    m_cyc++;
    #1;
    load = 1'b0;
    check_all(tag);
  endtask

  // Idle until the model's in-frame phase equals ph (bounded to one frame).
  task automatic run_to(input int ph, input string tag);
    for (int k = 0; k < FRAME; k++) begin
      if ((m_cyc % FRAME) == ph) break;
      cycle(1'b0, value, tag);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("reset_async");
    @(posedge clk);
    #1;
    check_all("reset_held");
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    load     = 1'b0;
    value    = '0;
    blank_lz = 1'b0;
    model_reset();

    // Reset and plain scan
    do_reset();
    chk("rst.an", 32'(an), 32'hE);
    chk("rst.code", 32'(digit_code), 32'h0);
    chk("rst.pending", 32'(pending), 32'h0);
    for (int k = 0; k < 4; k++) cycle(1'b0, '0, "scan");
    chk("scan.c4.an", 32'(an), 32'hD);
    for (int k = 4; k < 16; k++) cycle(1'b0, '0, "scan");
    chk("scan.c16.an", 32'(an), 32'hE);
    chk("scan.c16.fs", 32'(frame_start), 32'h1);
    cycle(1'b0, '0, "scan");
    chk("scan.c17.fs", 32'(frame_start), 32'h0);

    // Load mid-frame at idx=1
    run_to(5, "mid");
    cycle(1'b1, 16'h12AB, "mid.load");
    chk("mid.pending", 32'(pending), 32'h1);
    chk("mid.code_old", 32'(digit_code), 32'h0);
    run_to(0, "mid.wait");
    chk("mid.d0", 32'(digit_code), 32'hB);
    chk("mid.pend_clr", 32'(pending), 32'h0);
    for (int k = 0; k < FRAME; k++) cycle(1'b0, value, "mid.frame");

    // Last load wins
    run_to(2, "lw");
    cycle(1'b1, 16'h1111, "lw.first");
    cycle(1'b0, 16'h1111, "lw.gap");
    cycle(1'b1, 16'h2222, "lw.second");
    run_to(0, "lw.wait");
    for (int k = 0; k < FRAME; k++) begin
      chk("lw.code", 32'(digit_code), 32'h2);
      cycle(1'b0, value, "lw.frame");
    end

    // Leading-zero blanking
    blank_lz = 1'b1;
    cycle(1'b1, 16'h0050, "bl.load");
    run_to(0, "bl.wait");
    for (int k = 0; k < FRAME; k++) cycle(1'b0, value, "bl.0050");
    run_to(12, "bl.idx3");
    chk("bl.d3.an", 32'(an), 32'hF);
    chk("bl.d3.blank", 32'(digit_blank), 32'h1);
    blank_lz = 1'b0;
    #1;
    check_all("bl.live_off");
    chk("bl.live_off.an", 32'(an), 32'h7);
    blank_lz = 1'b1;
    #1;
    check_all("bl.live_on");
    cycle(1'b1, 16'h0000, "bl.zero_load");
    run_to(0, "bl.zero_wait");
    for (int k = 0; k < FRAME; k++) cycle(1'b0, value, "bl.zero");
    blank_lz = 1'b0;
    for (int k = 0; k < FRAME; k++) cycle(1'b0, value, "bl.off");

    // Coincident load and wrap
    run_to(3, "co");
    cycle(1'b1, 16'h00AA, "co.loadAA");
    run_to(FRAME - 1, "co.wait");
    cycle(1'b1, 16'h00BB, "co.loadBB");
    chk("co.d0", 32'(digit_code), 32'hA);
    chk("co.pending", 32'(pending), 32'h1);
    for (int k = 0; k < FRAME; k++) cycle(1'b0, value, "co.frame1");
    chk("co.next_d0", 32'(digit_code), 32'hB);
    chk("co.next_pending", 32'(pending), 32'h0);

    // Asynchronous reset mid-frame at idx=2
    run_to(8, "ar");
    cycle(1'b1, 16'h5678, "ar.load");
    rst_n = 1'b0;
    #1;
    chk("ar.an", 32'(an), 32'hE);
    chk("ar.code", 32'(digit_code), 32'h0);
    chk("ar.pending", 32'(pending), 32'h0);
    do_reset();
    for (int k = 0; k < FRAME + 2; k++) cycle(1'b0, value, "ar.after");

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 15) == 0) begin
        blank_lz = ~blank_lz;
        #1;
        check_all("rnd.blank_live");
      end
      if ($urandom_range(0, 3) == 0)
        cycle(1'b1, 16'($urandom_range(0, 3) == 0 ? $urandom_range(0, 255) : $urandom), "rnd");
      else
        cycle(1'b0, value, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
